// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO result holding unit.
// A two-entry FIFO buffers {high, low} result pairs from a producer. Entries
// retire in order into the architectural HI/LO registers when commit_en is
// high. Direct writes (mt_hi/mt_lo) land after the retire on the same edge.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered occupancy (count < 2), never on
// in_valid or commit_en. The producer must hold in_high/in_low stable while
// in_valid is high and in_ready is low.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_high,
  input  logic [WIDTH-1:0] in_low,
  input  logic             commit_en,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic [1:0]       pending_count
);

  logic [WIDTH-1:0] fifoHigh [2];
  logic [WIDTH-1:0] fifoLow  [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       countQ;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             doPush;
  logic             doPop;
  logic [1:0]       countNext;
  logic [WIDTH-1:0] hiNext;
  logic [WIDTH-1:0] loNext;

  // Handshake and retire qualifiers, plus next occupancy.
  always_comb begin
    in_ready  = (countQ != 2'd2);
    doPush    = in_valid && in_ready;
    doPop     = commit_en && (countQ != 2'd0);
    countNext = countQ;
    if (doPush && !doPop) begin
      countNext = countQ + 2'd1;
    end else if (!doPush && doPop) begin
      countNext = countQ - 2'd1;
    end
  end

  // Next HI/LO: retire first, then a direct write overrides its own half.
  always_comb begin
    hiNext = hiReg;
    loNext = loReg;
    if (doPop) begin
      hiNext = fifoHigh[rdPtr];
      loNext = fifoLow[rdPtr];
    end
    if (mt_hi) begin
      hiNext = mt_data;
    end
    if (mt_lo) begin
      loNext = mt_data;
    end
  end

  // FIFO storage, pointers, occupancy and architectural registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifoHigh[0] <= '0;
      fifoHigh[1] <= '0;
      fifoLow[0]  <= '0;
      fifoLow[1]  <= '0;
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      countQ      <= 2'd0;
      hiReg       <= '0;
      loReg       <= '0;
    end else begin
      if (doPush) begin
        fifoHigh[wrPtr] <= in_high;
        fifoLow[wrPtr]  <= in_low;
        wrPtr           <= ~wrPtr;
      end
      if (doPop) begin
        rdPtr <= ~rdPtr;
      end
      countQ <= countNext;
      hiReg  <= hiNext;
      loReg  <= loNext;
    end
  end

  // Architectural read port and status; pending entries are not forwarded.
  always_comb begin
    rd_data       = rd_sel ? hiReg : loReg;
    pending_count = countQ;
    busy          = (countQ != 2'd0);
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed table-driven checks for hilo_unit, plus hand-written
// sequences for same-cycle read behaviour.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_high;
  logic [W-1:0] in_low;
  logic         commit_en;
  logic         mt_hi;
  logic         mt_lo;
  logic [W-1:0] mt_data;
  logic         rd_sel;
  logic [W-1:0] rd_data;
  logic         busy;
  logic [1:0]   pending_count;

  int n_vec;
  int n_err;

  hilo_unit #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_high       (in_high),
    .in_low        (in_low),
    .commit_en     (commit_en),
    .mt_hi         (mt_hi),
    .mt_lo         (mt_lo),
    .mt_data       (mt_data),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .busy          (busy),
    .pending_count (pending_count)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst_n;
    logic         valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         commit;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] mtdata;
    logic [1:0]   exp_cnt;
    logic         exp_rdy;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic valid,
                              input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic commit, input logic mthi,
                              input logic mtlo, input logic [W-1:0] mtdata,
                              input logic [1:0] exp_cnt, input logic exp_rdy,
                              input logic [W-1:0] exp_hi,
                              input logic [W-1:0] exp_lo);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.hi = hi; v.lo = lo;
    v.commit = commit; v.mthi = mthi; v.mtlo = mtlo; v.mtdata = mtdata;
    v.exp_cnt = exp_cnt; v.exp_rdy = exp_rdy;
    v.exp_hi = exp_hi; v.exp_lo = exp_lo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one vector at the falling edge, hold across the rising edge
  task automatic drive(input vec_t v);
    @(negedge clock);
    reset_n   = v.rst_n;
    in_valid  = v.valid;
    in_high   = v.hi;
    in_low    = v.lo;
    commit_en = v.commit;
    mt_hi     = v.mthi;
    mt_lo     = v.mtlo;
    mt_data   = v.mtdata;
    @(posedge clock);
    #1;
  endtask

  // scoreboard check of all outputs after the edge; HI and LO read via rd_sel
  task automatic check_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    n_vec++;
    chk({tag, ".pending_count"}, W'(pending_count), W'(v.exp_cnt));
    chk({tag, ".busy"}, W'(busy), W'(v.exp_cnt != 2'd0));
    chk({tag, ".in_ready"}, W'(in_ready), W'(v.exp_rdy));
    rd_sel = 1'b1;
    #1;
    chk({tag, ".hi"}, rd_data, v.exp_hi);
    rd_sel = 1'b0;
    #1;
    chk({tag, ".lo"}, rd_data, v.exp_lo);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_high = '0; in_low = '0;
    commit_en = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; rd_sel = 1'b0;

    //              rst v  hi            lo            cm mh ml mtdata     cnt rdy expHi         expLo
    // reset state
    vecs.push_back(mk(0, 0, 0,            0,            0, 0, 0, 0,        0, 1, 0,            0));
    // single result with commit held high: one cycle in FIFO, then retire
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 32'h12345678, 1, 0, 0, 0,        1, 1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 32'hDEADBEEF, 32'h12345678));
    // commit with empty FIFO leaves HI/LO alone
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 32'hDEADBEEF, 32'h12345678));
    // fill: A, B, then C offered while full
    vecs.push_back(mk(1, 1, 1,            2,            0, 0, 0, 0,        1, 1, 32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mk(1, 1, 3,            4,            0, 0, 0, 0,        2, 0, 32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mk(1, 1, 7,            8,            0, 0, 0, 0,        2, 0, 32'hDEADBEEF, 32'h12345678));
    // drain: full during this cycle so C is still refused; A retires
    vecs.push_back(mk(1, 1, 7,            8,            1, 0, 0, 0,        1, 1, 1,            2));
    // B retires while C is accepted
    vecs.push_back(mk(1, 1, 7,            8,            1, 0, 0, 0,        1, 1, 3,            4));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 7,            8));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 7,            8));
    // simultaneous push/pop at count 1 keeps count and order
    vecs.push_back(mk(1, 1, 9,            10,           0, 0, 0, 0,        1, 1, 7,            8));
    vecs.push_back(mk(1, 1, 11,           12,           1, 0, 0, 0,        1, 1, 9,            10));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 11,           12));
    // retire {5,6} with mt_lo on the same edge
    vecs.push_back(mk(1, 1, 5,            6,            0, 0, 0, 0,        1, 1, 11,           12));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 1, 32'hFF,   0, 1, 5,            32'hFF));
    // mt_hi + mt_lo together, then mt_hi alone
    vecs.push_back(mk(1, 0, 0,            0,            0, 1, 1, 32'h55AA, 0, 1, 32'h55AA,     32'h55AA));
    vecs.push_back(mk(1, 0, 0,            0,            0, 1, 0, 32'h77,   0, 1, 32'h77,       32'h55AA));
    // retire with mt_hi override: LO takes retired value
    vecs.push_back(mk(1, 1, 32'h10,       32'h20,       0, 0, 0, 0,        1, 1, 32'h77,       32'h55AA));
    vecs.push_back(mk(1, 0, 0,            0,            1, 1, 0, 32'h99,   0, 1, 32'h99,       32'h20));
    // two pending, then reset overriding push, retire and mt writes
    vecs.push_back(mk(1, 1, 32'h111,      32'h222,      0, 0, 0, 0,        1, 1, 32'h99,       32'h20));
    vecs.push_back(mk(1, 1, 32'h333,      32'h444,      0, 0, 0, 0,        2, 0, 32'h99,       32'h20));
    vecs.push_back(mk(0, 1, 32'h555,      32'h666,      1, 1, 1, 32'hEE,   0, 1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,            1, 0, 0, 0,        0, 1, 0,            0));
    // set HI = 0xA, LO = 0xB, then leave {0xC,0xD} pending
    vecs.push_back(mk(1, 0, 0,            0,            0, 1, 1, 32'hB,    0, 1, 32'hB,        32'hB));
    vecs.push_back(mk(1, 0, 0,            0,            0, 1, 0, 32'hA,    0, 1, 32'hA,        32'hB));
    vecs.push_back(mk(1, 1, 32'hC,        32'hD,        0, 0, 0, 0,        1, 1, 32'hA,        32'hB));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // same-cycle rd_sel toggling with an entry pending: no forwarding
    @(negedge clock);
    in_valid = 1'b0;
    commit_en = 1'b0;
    rd_sel = 1'b1;
    #1;
    n_vec++;
    chk("rdsel_hi_pending", rd_data, 32'hA);
    rd_sel = 1'b0;
    #1;
    n_vec++;
    chk("rdsel_lo_pending", rd_data, 32'hB);
    rd_sel = 1'b1;
    #1;
    n_vec++;
    chk("rdsel_hi_again", rd_data, 32'hA);

    // retire the pending entry while watching HI through rd_sel
    commit_en = 1'b1;
    @(posedge clock);
    #1;
    n_vec++;
    chk("retired_hi", rd_data, 32'hC);
    rd_sel = 1'b0;
    #1;
    n_vec++;
    chk("retired_lo", rd_data, 32'hD);
    n_vec++;
    chk("retired_busy", W'(busy), W'(0));

    @(negedge clock);
    commit_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
